mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/mult_arbiter.sv | 91 +++++++++
 tb/tb_mult_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared sizing helpers for the arbitrated Q-format multiplier.
// Channel index width, product slice bounds and saturation constants.
package mult_pkg;

    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Q1.(W-1) x Q1.(W-1) gives Q2.(2W-2); drop the duplicated sign bit and the low fraction.
    function automatic int prod_msb(input int dw);
        return 2 * dw - 2;
    endfunction

    function automatic int prod_lsb(input int dw);
        return dw - 1;
    endfunction

    function automatic logic [63:0] sat_pos(input int dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] q_min(input int dw);
        return 64'd1 << (dw - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first enabled requester after last_grant wins.
// Purely combinational; the caller qualifies the grant with its own stall condition.
module rr_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int CH_WIDTH = 2
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [NUM_CH-1:0]   enable,
    input  logic [CH_WIDTH-1:0] last_grant,
    output logic [NUM_CH-1:0]   grant,
    output logic [CH_WIDTH-1:0] grant_idx,
    output logic                grant_vld
);

    logic [NUM_CH-1:0] cand;

    assign cand = req & enable;

    // Two passes: channels above last_grant first, then wrap around from channel 0.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!grant_vld && cand[j] && (j > int'(last_grant))) begin
                grant_vld = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = CH_WIDTH'(j);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!grant_vld && cand[j]) begin
                grant_vld = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = CH_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// NUM_CH requesters share one saturating Q1.(W-1) multiplier via round-robin arbitration.
// Two-stage pipeline; both stages hold and all grants drop while the output is stalled.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    localparam int CH_WIDTH  = ch_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_a_tdata,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_b_tdata,
    input  logic [NUM_CH-1:0]            req_tvalid,
    output logic [NUM_CH-1:0]            req_tready,
    output logic [DATA_WIDTH-1:0]        data_o_tdata,
    output logic [CH_WIDTH-1:0]          data_o_tdest,
    output logic                         data_o_tvalid,
    input  logic                         data_o_tready,
    output logic                         busy
);

    localparam int P_MSB = prod_msb(DATA_WIDTH);
    localparam int P_LSB = prod_lsb(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] Q_MAX = DATA_WIDTH'(sat_pos(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] Q_MIN = DATA_WIDTH'(q_min(DATA_WIDTH));

    logic [CH_WIDTH-1:0]             last_grant;
    logic [CH_WIDTH-1:0]             grant_idx;
    logic [NUM_CH-1:0]               grant;
    logic                            grant_vld;
    logic                            adv;
    logic signed [DATA_WIDTH-1:0]    a_sel;
    logic signed [DATA_WIDTH-1:0]    b_sel;
    logic signed [2*DATA_WIDTH-1:0]  prod;
    logic [DATA_WIDTH-1:0]           mult_res;
    logic                            unused_prod_bits;

    logic                            s1_vld;
    logic [DATA_WIDTH-1:0]           s1_dat;
    logic [CH_WIDTH-1:0]             s1_dest;

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .CH_WIDTH (CH_WIDTH)
    ) u_rr_arbiter (
        .req        (req_tvalid),
        .enable     (ch_enable),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    assign adv        = !data_o_tvalid || data_o_tready;
    assign req_tready = (adv && !reset) ? grant : '0;
    assign busy       = s1_vld | data_o_tvalid;

    assign a_sel = req_a_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign b_sel = req_b_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign prod  = a_sel * b_sel;

    // (-1) * (-1) is the only product that overflows the Q1 range.
    assign mult_res = ((a_sel == Q_MIN) && (b_sel == Q_MIN)) ? Q_MAX : prod[P_MSB:P_LSB];

    assign unused_prod_bits = ^{prod[2*DATA_WIDTH-1], prod[P_LSB-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant    <= CH_WIDTH'(NUM_CH - 1);
            s1_vld        <= 1'b0;
            s1_dat        <= '0;
            s1_dest       <= '0;
            data_o_tvalid <= 1'b0;
            data_o_tdata  <= '0;
            data_o_tdest  <= '0;
        end else if (adv) begin
            s1_vld        <= grant_vld;
            s1_dat        <= mult_res;
            s1_dest       <= grant_idx;
            data_o_tvalid <= s1_vld;
            data_o_tdata  <= s1_dat;
            data_o_tdest  <= s1_dest;
            if (grant_vld) begin
                last_grant <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized self-checking bench for mult_arbiter against a queue-free two-slot reference model.
module tb_mult_arbiter;

    localparam int DW  = 16;
    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ch_enable;
    logic [63:0] req_a_tdata;
    logic [63:0] req_b_tdata;
    logic [3:0]  req_tvalid;
    logic [3:0]  req_tready;
    logic [15:0] data_o_tdata;
    logic [1:0]  data_o_tdest;
    logic        data_o_tvalid;
    logic        data_o_tready;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;

    // Reference state: round-robin pointer plus the two pipeline slots.
    int          m_last;
    logic        m_s1v, m_s2v;
    logic [15:0] m_s1d, m_s2d;
    logic [1:0]  m_s1t, m_s2t;

    always #5 clk = ~clk;

    mult_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
        .clk           (clk),
        .reset         (reset),
        .ch_enable     (ch_enable),
        .req_a_tdata   (req_a_tdata),
        .req_b_tdata   (req_b_tdata),
        .req_tvalid    (req_tvalid),
        .req_tready    (req_tready),
        .data_o_tdata  (data_o_tdata),
        .data_o_tdest  (data_o_tdest),
        .data_o_tvalid (data_o_tvalid),
        .data_o_tready (data_o_tready),
        .busy          (busy)
    );

    function automatic logic [15:0] exp_mul(input logic [15:0] a, input logic [15:0] b);
        longint p;
        if (a == 16'h8000 && b == 16'h8000) return 16'h7FFF;
        p = longint'($signed(a)) * longint'($signed(b));
        return 16'(p >>> 15);
    endfunction

    function automatic int exp_winner();
        for (int i = 1; i <= NCH; i++) begin
            int k;
            k = (m_last + i) % NCH;
            if (req_tvalid[k] && ch_enable[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_tready();
        int w;
        if (m_s2v && !data_o_tready) return 4'b0000;
        w = exp_winner();
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    function automatic logic [15:0] opnd();
        case ($urandom_range(0, 3))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic rand_ops();
        for (int k = 0; k < NCH; k++) begin
            req_a_tdata[k*16 +: 16] = opnd();
            req_b_tdata[k*16 +: 16] = opnd();
        end
    endtask

    task automatic model_reset();
        m_last = NCH - 1;
        m_s1v = 1'b0; m_s2v = 1'b0;
        m_s1d = '0;   m_s2d = '0;
        m_s1t = '0;   m_s2t = '0;
    endtask

    // Advance one clock and update the reference from the inputs held across the edge.
    task automatic tick();
        int   w;
        logic adv;
        w   = exp_winner();
        adv = !m_s2v || data_o_tready;
        @(posedge clk);
        if (adv) begin
            m_s2v = m_s1v; m_s2d = m_s1d; m_s2t = m_s1t;
            m_s1v = (w >= 0);
            if (w >= 0) begin
                m_s1d  = exp_mul(req_a_tdata[w*16 +: 16], req_b_tdata[w*16 +: 16]);
                m_s1t  = 2'(w);
                m_last = w;
                n_in++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; ch_enable = 4'hF; req_tvalid = 4'hF; data_o_tready = 1'b1;
        req_a_tdata = '0; req_b_tdata = '0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({req_tready, data_o_tvalid, data_o_tdata, data_o_tdest, busy} !== 24'h0) begin
            errors++;
            $display("FAIL reset_async: tready=%b vld=%b dat=%h dest=%0d busy=%b, expected all zero",
                     req_tready, data_o_tvalid, data_o_tdata, data_o_tdest, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (req_tready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: req_tready=%b expected 0001", req_tready);
        end
        req_tvalid = 4'h0;
        #1;
    endtask

    task automatic test_basic();
        req_a_tdata[15:0] = 16'h4000; req_b_tdata[15:0] = 16'h4000;
        req_tvalid = 4'b0001;
        #1;
        tick();
        req_tvalid = 4'b0000;
        #1;
        checks++;
        if (data_o_tvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_lat1: vld=%b busy=%b expected vld=0 busy=1", data_o_tvalid, busy);
        end
        tick();
        #1;
        checks++;
        if (data_o_tvalid !== 1'b1 || data_o_tdata !== 16'h2000 || data_o_tdest !== 2'd0) begin
            errors++;
            $display("FAIL basic_result: vld=%b dat=%h dest=%0d expected vld=1 dat=2000 dest=0",
                     data_o_tvalid, data_o_tdata, data_o_tdest);
        end
        tick();
        #1;
        checks++;
        if (data_o_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: vld=%b busy=%b expected 0 0", data_o_tvalid, busy);
        end
    endtask

    task automatic test_round_robin();
        req_tvalid = 4'hF; ch_enable = 4'hF; data_o_tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            #1;
            checks++;
            if (req_tready !== 4'(1 << ((i + 1) % NCH))) begin
                errors++;
                $display("FAIL rr_order: cycle %0d req_tready=%b expected %b",
                         i, req_tready, 4'(1 << ((i + 1) % NCH)));
            end
            checks++;
            if (data_o_tvalid !== m_s2v ||
                (m_s2v && {data_o_tdata, data_o_tdest} !== {m_s2d, m_s2t})) begin
                errors++;
                $display("FAIL rr_output: vld=%b dat=%h dest=%0d expected vld=%b dat=%h dest=%0d",
                         data_o_tvalid, data_o_tdata, data_o_tdest, m_s2v, m_s2d, m_s2t);
            end
            tick();
        end
        req_tvalid = 4'h0;
        tick(); tick();
    endtask

    task automatic test_saturation();
        logic [15:0] tbl_a [5] = '{16'h8000, 16'h8000, 16'h4000, 16'hC000, 16'h7FFF};
        logic [15:0] tbl_b [5] = '{16'h8000, 16'h7FFF, 16'h4000, 16'h4000, 16'h7FFF};
        logic [15:0] tbl_r [5] = '{16'h7FFF, 16'h8001, 16'h2000, 16'hE000, 16'h7FFE};
        for (int i = 0; i < 5; i++) begin
            req_a_tdata[32 +: 16] = tbl_a[i];
            req_b_tdata[32 +: 16] = tbl_b[i];
            req_tvalid = 4'b0100;
            #1;
            tick();
            req_tvalid = 4'b0000;
            tick();
            #1;
            checks++;
            if (data_o_tvalid !== 1'b1 || data_o_tdata !== tbl_r[i] || data_o_tdest !== 2'd2) begin
                errors++;
                $display("FAIL sat_%0d: %h*%h gave vld=%b dat=%h dest=%0d, expected %h dest 2",
                         i, tbl_a[i], tbl_b[i], data_o_tvalid, data_o_tdata, data_o_tdest, tbl_r[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int dut_out = 0;
        int in0;
        in0 = n_in;
        ch_enable = 4'hF;
        for (int c = 0; c < 14; c++) begin
            data_o_tready = !(c >= 3 && c < 8);
            req_tvalid    = (c < 10) ? 4'hF : 4'h0;
            rand_ops();
            #1;
            checks++;
            if (req_tready !== exp_tready() || (!data_o_tready && req_tready !== 4'b0000)) begin
                errors++;
                $display("FAIL stall_grant: cycle %0d req_tready=%b expected %b", c, req_tready, exp_tready());
            end
            checks++;
            if (data_o_tvalid !== m_s2v || busy !== (m_s1v | m_s2v) ||
                (m_s2v && {data_o_tdata, data_o_tdest} !== {m_s2d, m_s2t})) begin
                errors++;
                $display("FAIL stall_output: cycle %0d vld=%b dat=%h dest=%0d busy=%b expected vld=%b dat=%h dest=%0d",
                         c, data_o_tvalid, data_o_tdata, data_o_tdest, busy, m_s2v, m_s2d, m_s2t);
            end
            if (data_o_tvalid && data_o_tready) dut_out++;
            tick();
        end
        checks++;
        if (dut_out != n_in - in0) begin
            errors++;
            $display("FAIL stall_count: outputs=%0d accepted=%0d", dut_out, n_in - in0);
        end
    endtask

    task automatic test_enable_mask();
        logic [3:0] prev = 4'b0000;
        ch_enable = 4'b1010; req_tvalid = 4'hF; data_o_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            #1;
            checks++;
            if (req_tready !== exp_tready() || (req_tready & ~ch_enable) !== 4'b0000 ||
                (prev != 4'b0000 && req_tready !== ((prev == 4'b0010) ? 4'b1000 : 4'b0010))) begin
                errors++;
                $display("FAIL mask_grant: cycle %0d req_tready=%b prev=%b", i, req_tready, prev);
            end
            prev = req_tready;
            tick();
        end
        req_tvalid = 4'h0;
        ch_enable  = 4'hF;
        tick(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_tvalid    = 4'($urandom());
            ch_enable     = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
            data_o_tready = ($urandom_range(0, 3) != 0);
            rand_ops();
            #1;
            checks++;
            if (req_tready !== exp_tready()) begin
                errors++;
                $display("FAIL rand_grant: cycle %0d req_tready=%b expected %b", c, req_tready, exp_tready());
            end
            checks++;
            if (data_o_tvalid !== m_s2v || busy !== (m_s1v | m_s2v) ||
                (m_s2v && {data_o_tdata, data_o_tdest} !== {m_s2d, m_s2t})) begin
                errors++;
                $display("FAIL rand_output: cycle %0d vld=%b dat=%h dest=%0d busy=%b expected vld=%b dat=%h dest=%0d",
                         c, data_o_tvalid, data_o_tdata, data_o_tdest, busy, m_s2v, m_s2d, m_s2t);
            end
            tick();
        end
        req_tvalid = 4'h0; data_o_tready = 1'b1; ch_enable = 4'hF;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_midflight();
        req_tvalid = 4'hF; data_o_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            #1;
            tick();
        end
        checks++;
        if (data_o_tvalid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: vld=%b busy=%b expected 1 1", data_o_tvalid, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (data_o_tvalid !== 1'b0 || busy !== 1'b0 || req_tready !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_async: vld=%b busy=%b tready=%b expected 0 0 0000",
                     data_o_tvalid, busy, req_tready);
        end
        @(negedge clk);
        reset = 1'b0;
        req_tvalid = 4'h0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (data_o_tvalid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale: cycle %0d vld=%b busy=%b expected 0 0", i, data_o_tvalid, busy);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_saturation();
        test_stall();
        test_enable_mask();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
